// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory interface.
// Holds the response tag, the address-range helpers and the default word-index width.
package instr_mem_pkg;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;
    localparam int unsigned WORD_IDX_W          = $clog2(DEFAULT_DEPTH_WORDS);

    typedef struct packed {
        logic valid;
        logic err;
        logic discard;
    } resp_tag_t;

    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // An address below base wraps to a huge offset, so the lower-bound
    // test has to be explicit.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        return (addr >= base) && (word_index(addr, base) < 32'(depth));
    endfunction

    function automatic resp_tag_t mark_flush(input resp_tag_t tag, input logic flush);
        resp_tag_t t;
        t         = tag;
        t.discard = tag.discard | (flush & tag.valid);
        return t;
    endfunction

endpackage

// File: rtl/instr_resp_pipe.sv
// Fixed-depth response tag pipeline that mirrors the SRAM read latency.
// A flush marks every in-flight tag, including the one retiring this cycle.
module instr_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_err,
    input  logic flush,
    output logic retire_valid,
    output logic retire_err,
    output logic retire_discard
);

    resp_tag_t stage_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // A tag pushed in a flush cycle belongs to the redirected stream.
            stage_q[0] <= '{valid: push, err: push_err, discard: 1'b0};
            for (int i = 1; i < int'(LATENCY); i++) begin
                stage_q[i] <= mark_flush(stage_q[i-1], flush);
            end
        end
    end

    assign retire_valid   = stage_q[LATENCY-1].valid;
    assign retire_err     = stage_q[LATENCY-1].err;
    assign retire_discard = stage_q[LATENCY-1].discard | flush;

endmodule

// File: rtl/instr_mem_if.sv
// Instruction-side memory interface: grants fetch requests, drives the SRAM,
// and returns in-order responses, dropping those overtaken by a flush.
module instr_mem_if
    import instr_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               instr_req_i,
    input  logic [31:0]                        instr_addr_i,
    output logic                               instr_gnt_o,
    output logic                               instr_rvalid_o,
    output logic [31:0]                        instr_rdata_o,
    output logic                               instr_err_o,
    input  logic                               flush_i,
    output logic                               mem_en_o,
    output logic [$clog2(MEM_DEPTH_WORDS)-1:0] mem_addr_o,
    input  logic                               mem_ready_i,
    input  logic [31:0]                        mem_rdata_i,
    output logic                               busy_o
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count_q;
    logic             in_range;
    logic             retire_valid;
    logic             retire_err;
    logic             retire_discard;
    logic             deliver;

    assign in_range = addr_in_range(instr_addr_i, BASE_ADDR, MEM_DEPTH_WORDS);

    // Only the registered count limits grants; a same-cycle retire frees
    // its slot one cycle later, keeping the grant path short.
    assign instr_gnt_o = instr_req_i & mem_ready_i & (count_q < CNT_W'(MAX_OUTSTANDING));
    assign mem_en_o    = instr_gnt_o & in_range;
    assign mem_addr_o  = IDX_W'(word_index(instr_addr_i, BASE_ADDR));
    assign busy_o      = (count_q != '0);

    instr_resp_pipe #(
        .LATENCY (MEM_LATENCY)
    ) u_resp_pipe (
        .clk            (clk),
        .rst            (rst),
        .push           (instr_gnt_o),
        .push_err       (~in_range),
        .flush          (flush_i),
        .retire_valid   (retire_valid),
        .retire_err     (retire_err),
        .retire_discard (retire_discard)
    );

    assign deliver = retire_valid & ~retire_discard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(instr_gnt_o) - CNT_W'(retire_valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            instr_err_o    <= 1'b0;
        end else begin
            instr_rvalid_o <= deliver;
            if (deliver) begin
                instr_err_o   <= retire_err;
                instr_rdata_o <= retire_err ? '0 : mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_if.sv
// Directed and randomized bench for instr_mem_if against a transaction-level
// queue model of outstanding requests; SRAM model fixed at two-cycle latency.
module tb_instr_mem_if;

    localparam int unsigned L     = 2;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        flush_i;
    logic        mem_en_o;
    logic [11:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    instr_mem_if #(
        .BASE_ADDR       (BASE),
        .MEM_DEPTH_WORDS (DEPTH),
        .MEM_LATENCY     (L),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .flush_i        (flush_i),
        .mem_en_o       (mem_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ready_i    (mem_ready_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'hDEAD_BEEF ^ (idx * 32'h9E37_79B9);
    endfunction

    // SRAM: data for a read enabled in cycle N is presented in cycle N+2;
    // otherwise the bus carries junk.
    logic        s_en   = 1'b0;
    logic [11:0] s_addr = '0;
    always @(posedge clk) begin
        s_en        <= mem_en_o;
        s_addr      <= mem_addr_o;
        mem_rdata_i <= s_en ? mem_word({20'd0, s_addr}) : $urandom;
    end

    typedef struct {
        int          g;
        logic        err;
        logic        disc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          cyc;
    logic        exp_rvalid;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          n_pass;
    int          n_fail;
    int          n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic req, input logic [31:0] addr,
                        input logic fl, input logic rdy);
        logic        in_r;
        logic        gnt_e;
        logic [31:0] off;
        ent_t        e;
        instr_req_i  = req;
        instr_addr_i = addr;
        flush_i      = fl;
        mem_ready_i  = rdy;
        @(negedge clk);
        chk("rvalid", {31'd0, instr_rvalid_o}, {31'd0, exp_rvalid});
        chk("rdata", instr_rdata_o, exp_rdata);
        chk("err", {31'd0, instr_err_o}, {31'd0, exp_err});
        chk("busy", {31'd0, busy_o}, {31'd0, q.size() != 0});
        off   = addr - BASE;
        in_r  = (addr >= BASE) && (off / 4 < DEPTH);
        gnt_e = req && rdy && (q.size() < MAXO);
        chk("gnt", {31'd0, instr_gnt_o}, {31'd0, gnt_e});
        chk("mem_en", {31'd0, mem_en_o}, {31'd0, gnt_e && in_r});
        if (gnt_e && in_r) chk("mem_addr", {20'd0, mem_addr_o}, (off / 4) % DEPTH);
        chk("count_bound", {31'd0, 32'(dut.count_q) <= MAXO}, 32'd1);

        if (fl) foreach (q[i]) q[i].disc = 1'b1;
        exp_rvalid = 1'b0;
        if (q.size() > 0 && cyc - q[0].g == int'(L)) begin
            e = q.pop_front();
            if (!e.disc) begin
                exp_rvalid = 1'b1;
                exp_err    = e.err;
                exp_rdata  = e.data;
            end
        end
        if (gnt_e) begin
            e.g    = cyc;
            e.err  = !in_r;
            e.disc = 1'b0;
            e.data = in_r ? mem_word((off / 4) % DEPTH) : 32'd0;
            q.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rvalid"}, {31'd0, instr_rvalid_o}, 32'd0);
        chk({tag, "_rdata"}, instr_rdata_o, 32'd0);
        chk({tag, "_err"}, {31'd0, instr_err_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
        exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        rst = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = '0; flush_i = 1'b0; mem_ready_i = 1'b1;
        #1;
        check_reset_state("por");
        chk("por_gnt", {31'd0, instr_gnt_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read
        step(1'b1, 32'h0000_0010, 1'b0, 1'b1);
        idle(4);

        // Back-to-back: third request must wait for the outstanding limit
        step(1'b1, 32'h0000_0000, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0004, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0008, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0008, 1'b0, 1'b1);
        idle(4);

        // Out of range and last valid word
        step(1'b1, 32'h0000_4000, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 32'h0000_3FFF, 1'b0, 1'b1);
        idle(4);

        // Flush with a new request in the same cycle
        step(1'b1, 32'h0000_0020, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        idle(4);

        // Flush with two in flight, one of them retiring
        step(1'b1, 32'h0000_0040, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0044, 1'b0, 1'b1);
        step(1'b0, 32'h0000_0000, 1'b1, 1'b1);
        idle(4);

        // Backpressure
        repeat (3) step(1'b1, 32'h0000_0050, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0050, 1'b0, 1'b1);
        idle(4);

        // Reset while a response is visible and another is pending
        step(1'b1, 32'h0000_0030, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0034, 1'b0, 1'b1);
        step(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        chk("pre_rst_rvalid", {31'd0, instr_rvalid_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_state("mid_rst");
        q.delete();
        exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = $urandom_range(0, 32'h0000_4003);
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) != 0);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
